mc_ctrl: RTL

- Multi-cycle main controller for the single-issue MIPS core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, regfile and memory ports.
- Drives the id-stage selects (RegWr, WDSel, RDSel), the ALU controls and the PC-update controls.
- Handles req/ack handshakes to instruction and data memory.

---
 rtl/mc_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller (FETCH/DECODE/EXEC/MEM/WB) for the single-issue MIPS core.
// Build option: define ILLEGAL_TRAP_EN to halt on an illegal instruction instead of retiring it as a NOP.
module mc_ctrl #(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              zero,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    output logic              imem_req,
    output logic              IRWr,
    output logic              dmem_req,
    output logic              MemWr,
    output logic              RegWr,
    output logic [1:0]        WDSel,
    output logic [1:0]        RDSel,
    output logic              ALUSrc,
    output logic [ALUOPW-1:0] ALUOp,
    output logic              PCWr,
    output logic [1:0]        NPCSel,
    output logic              retire,
    output logic              illegal
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'('h00);
    localparam logic [OPW-1:0] OP_J     = OPW'('h02);
    localparam logic [OPW-1:0] OP_JAL   = OPW'('h03);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'('h04);
    localparam logic [OPW-1:0] OP_ADDIU = OPW'('h09);
    localparam logic [OPW-1:0] OP_ORI   = OPW'('h0d);
    localparam logic [OPW-1:0] OP_LUI   = OPW'('h0f);
    localparam logic [OPW-1:0] OP_LW    = OPW'('h23);
    localparam logic [OPW-1:0] OP_SW    = OPW'('h2b);

    localparam logic [OPW-1:0] FN_JR    = OPW'('h08);
    localparam logic [OPW-1:0] FN_ADDU  = OPW'('h21);
    localparam logic [OPW-1:0] FN_SUBU  = OPW'('h23);
    localparam logic [OPW-1:0] FN_AND   = OPW'('h24);
    localparam logic [OPW-1:0] FN_OR    = OPW'('h25);
    localparam logic [OPW-1:0] FN_SLT   = OPW'('h2a);

    localparam logic [ALUOPW-1:0] ALU_ADD = ALUOPW'(0);
    localparam logic [ALUOPW-1:0] ALU_SUB = ALUOPW'(1);
    localparam logic [ALUOPW-1:0] ALU_AND = ALUOPW'(2);
    localparam logic [ALUOPW-1:0] ALU_OR  = ALUOPW'(3);
    localparam logic [ALUOPW-1:0] ALU_SLT = ALUOPW'(4);
    localparam logic [ALUOPW-1:0] ALU_LUI = ALUOPW'(5);

    state_t            state;
    logic [OPW-1:0]    op;
    logic [OPW-1:0]    funct;
    logic              funct_alu;
    logic [ALUOPW-1:0] r_alu_op;
    logic              is_rtype, is_jr, is_itype, is_lw, is_sw, is_beq, is_j, is_jal, is_exec;

    // Only opcode and funct are kept; the register/immediate fields go to the datapath directly.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[31-OPW:OPW];

    always_comb begin
        funct_alu = 1'b1;
        r_alu_op  = ALU_ADD;
        case (funct)
            FN_ADDU: r_alu_op = ALU_ADD;
            FN_SUBU: r_alu_op = ALU_SUB;
            FN_AND:  r_alu_op = ALU_AND;
            FN_OR:   r_alu_op = ALU_OR;
            FN_SLT:  r_alu_op = ALU_SLT;
            default: funct_alu = 1'b0;
        endcase
        is_rtype = (op == OP_RTYPE);
        is_jr    = is_rtype && (funct == FN_JR);
        is_itype = (op == OP_ADDIU) || (op == OP_ORI) || (op == OP_LUI);
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_beq   = (op == OP_BEQ);
        is_j     = (op == OP_J);
        is_jal   = (op == OP_JAL);
        is_exec  = (is_rtype && (funct_alu || is_jr)) || is_itype || is_lw || is_sw || is_beq;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
            op    <= '0;
            funct <= '0;
        end else begin
            case (state)
                FETCH: if (imem_ack) begin
                    op    <= instr[31 -: OPW];
                    funct <= instr[OPW-1:0];
                    state <= DECODE;
                end
                DECODE: begin
                    if (is_j)         state <= FETCH;
                    else if (is_jal)  state <= WB;
                    else if (is_exec) state <= EXEC;
                    else
`ifdef ILLEGAL_TRAP_EN
                        state <= HALT;
`else
                        state <= FETCH;
`endif
                end
                EXEC:    state <= (is_lw || is_sw) ? MEM : ((is_beq || is_jr) ? FETCH : WB);
                MEM:     if (dmem_ack) state <= is_lw ? WB : FETCH;
                WB:      state <= FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // NOTE: every output is defaulted first so paths that skip an assignment cannot infer a latch.
    always_comb begin
        imem_req = 1'b0;
        IRWr     = 1'b0;
        dmem_req = 1'b0;
        MemWr    = 1'b0;
        RegWr    = 1'b0;
        WDSel    = 2'd0;
        RDSel    = 2'd0;
        ALUSrc   = 1'b0;
        ALUOp    = ALU_ADD;
        PCWr     = 1'b0;
        NPCSel   = 2'd0;
        retire   = 1'b0;
        illegal  = 1'b0;
        if (rst) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    IRWr     = imem_ack;
                end
                DECODE: begin
                    if (is_j) begin
                        PCWr   = 1'b1;
                        NPCSel = 2'd2;
                        retire = 1'b1;
                    end
`ifndef ILLEGAL_TRAP_EN
                    else if (!is_jal && !is_exec) begin
                        PCWr   = 1'b1;
                        retire = 1'b1;
                    end
`endif
                end
                EXEC: begin
                    // beq and jr compare/forward register operands, so only I-type and lw/sw take imm32.
                    ALUSrc = is_itype || is_lw || is_sw;
                    if (is_rtype)                 ALUOp = r_alu_op;
                    else if (is_beq)              ALUOp = ALU_SUB;
                    else if (op == OP_ORI)        ALUOp = ALU_OR;
                    else if (op == OP_LUI)        ALUOp = ALU_LUI;
                    if (is_beq) begin
                        PCWr   = 1'b1;
                        NPCSel = zero ? 2'd1 : 2'd0;
                        retire = 1'b1;
                    end else if (is_jr) begin
                        PCWr   = 1'b1;
                        NPCSel = 2'd3;
                        retire = 1'b1;
                    end
                end
                MEM: begin
                    dmem_req = 1'b1;
                    MemWr    = is_sw;
                    if (dmem_ack && is_sw) begin
                        PCWr   = 1'b1;
                        retire = 1'b1;
                    end
                end
                WB: begin
                    RegWr  = 1'b1;
                    PCWr   = 1'b1;
                    retire = 1'b1;
                    if (is_jal) begin
                        WDSel  = 2'd2;
                        RDSel  = 2'd2;
                        NPCSel = 2'd2;
                    end else if (is_lw) begin
                        WDSel = 2'd1;
                        RDSel = 2'd1;
                    end else if (!is_rtype) begin
                        RDSel = 2'd1;
                    end
                end
                HALT: begin
`ifdef ILLEGAL_TRAP_EN
                    illegal = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
